seg_scan_ctrl: RTL



---
 rtl/seg_pkg.sv | 39 +++
 rtl/display.sv | 11 +
 rtl/seg_scan_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-segment table for the seven-segment scan controller.
// Segment vectors are ordered {a,b,c,d,e,f,g} and are active-low.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/display.sv
// Existing 4-bit hex to seven-segment decoder (active-low segments).
module display
  import seg_pkg::*;
(
  input  logic [3:0] b,
  output logic [6:0] seven
);

  always_comb seven = hex_to_seg(b);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-aligned value updates,
// leading-zero suppression and an anti-ghosting guard at the start of each digit slot.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   upd_data,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic                  lz_en,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [DW-1:0]     DIV_LAST   = DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0]     GUARD_CNT  = DW'(GUARD);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_ALL_OFF = AN_OFF[DIGITS-1:0];

  logic [DW-1:0]       div_cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] active;
  logic [4*DIGITS-1:0] shadow;
  logic                pending;

  logic                slot_end;
  logic                wrap;
  logic                accept;
  logic                blank;
  logic [3:0]          nib;
  logic [6:0]          dec_seg;
  logic [DIGITS-1:0]   an_nxt;
  logic [6:0]          seg_nxt;

  assign slot_end  = (div_cnt == DIV_LAST);
  assign wrap      = slot_end && (idx == IDX_LAST);
  assign upd_ready = !pending;
  assign accept    = upd_valid && !pending;

  assign nib = active[4*idx +: 4];

  // A digit is blank when it and every more-significant nibble are zero.
  assign blank = lz_en && (idx != '0) && ((active >> {idx, 2'b00}) == '0);

  display u_display (
    .b     (nib),
    .seven (dec_seg)
  );

  always_comb begin
    an_nxt = AN_ALL_OFF;
    if (div_cnt >= GUARD_CNT) an_nxt[idx] = 1'b0;
    seg_nxt = blank ? SEG_BLANK : dec_seg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (slot_end) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Commit only at frame wrap; a transfer accepted at wrap waits a whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else if (wrap && pending) begin
      active  <= shadow;
      pending <= 1'b0;
    end else if (accept) begin
      shadow  <= upd_data;
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= AN_ALL_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= !dp_mask[idx];
      frame_done <= wrap;
    end
  end

endmodule
